// File: rtl/ahfp_mod_pi_arb.sv
// Round-robin arbiter sharing one ahfp_mod_pi pipeline between N_REQ requesters; result steered back by tag.
// Define AHFP_MOD_PI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ahfp_mod_pi_arb #(
   parameter int N_REQ   = 4,
   parameter int LATENCY = 24,
   parameter int TAG_W   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [32*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]    req_ready,
   input  logic                hold,
   output logic [31:0]         mod_data,
   input  logic [31:0]         mod_result,
   output logic [N_REQ-1:0]    resp_valid,
   output logic [31:0]         resp_data,
   output logic                busy
);
   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] id;
   } tag_t;

   // Stage 0 rides alongside mod_data; stages 1..LATENCY track the pipeline so the last lines up with mod_result.
   tag_t             tag_q [LATENCY+1];
   logic             gnt_vld;
   logic [TAG_W-1:0] gnt_id;
   logic [31:0]      gnt_data;

`ifdef AHFP_MOD_PI_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (req_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_id  = TAG_W'(k);
         end
      end
      if (hold || rst) gnt_vld = 1'b0;
   end
`else
   logic [TAG_W-1:0]   ptr_q;
   logic [2*N_REQ-1:0] rot_vld;
   logic [TAG_W:0]     idx;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      rot_vld = {req_valid, req_valid} >> ptr_q;
      // Descending scan: the smallest offset from ptr is written last and wins.
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (rot_vld[k]) begin
            gnt_vld = 1'b1;
            idx     = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (idx >= (TAG_W+1)'(N_REQ)) idx = idx - (TAG_W+1)'(N_REQ);
            gnt_id  = idx[TAG_W-1:0];
         end
      end
      if (hold || rst) gnt_vld = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr_q <= '0;
      else if (gnt_vld)
         ptr_q <= (gnt_id == TAG_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
   end
`endif

   always_comb begin
      req_ready = '0;
      gnt_data  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (gnt_vld && gnt_id == TAG_W'(j)) begin
            req_ready[j] = 1'b1;
            gnt_data     = req_data[32*j +: 32];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mod_data   <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
      end else begin
         mod_data <= gnt_vld ? gnt_data : 32'h0;
         tag_q[0] <= {gnt_vld, gnt_id};
         for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
         for (int j = 0; j < N_REQ; j++)
            resp_valid[j] <= tag_q[LATENCY].vld && (tag_q[LATENCY].id == TAG_W'(j));
         if (tag_q[LATENCY].vld) resp_data <= mod_result;
      end
   end

   always_comb begin
      busy = |resp_valid;
      for (int i = 0; i <= LATENCY; i++) busy = busy | tag_q[i].vld;
   end
endmodule

// File: tb/tb_ahfp_mod_pi_arb.sv
// Bench for ahfp_mod_pi_arb: directed literal scenarios plus random traffic against a queue-based reference model.
module tb_ahfp_mod_pi_arb;
   localparam int N   = 4;
   localparam int LAT = 24;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [32*N-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              hold;
   logic [31:0]       mod_data;
   logic [31:0]       mod_result;
   logic [N-1:0]      resp_valid;
   logic [31:0]       resp_data;
   logic              busy;

   ahfp_mod_pi_arb #(.N_REQ(N), .LATENCY(LAT), .TAG_W(3)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .hold(hold), .mod_data(mod_data), .mod_result(mod_result),
      .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
   );

   // Stand-in for ahfp_mod_pi: LAT-edge delay line, result = operand ^ 1.
   logic [31:0] dl [LAT];
   always @(posedge clk) begin
      dl[0] <= mod_data;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
   end
   assign mod_result = dl[LAT-1] ^ 32'h1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
   endtask

   // Reference model: which requester wins, and a queue of expected responses with due cycles.
   typedef struct {
      int          due;
      int          id;
      logic [31:0] res;
   } exp_t;
   exp_t        q[$];
   int          m_ptr  = 0;
   int          m_gnt  = -1;
   logic [31:0] m_mod  = '0;
   logic [31:0] m_last = '0;
   logic [31:0] m_rv;
   logic [31:0] m_rdy;

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req_ready", 32'(req_ready), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_resp_valid", 32'(resp_valid), 32'h0);
         chk("rst_resp_data", resp_data, 32'h0);
         chk("rst_mod_data", mod_data, 32'h0);
         q.delete();
         m_ptr  = 0;
         m_gnt  = -1;
         m_mod  = '0;
         m_last = '0;
      end else begin
         chk("mod_data", mod_data, m_mod);
         m_rv = '0;
         if (q.size() > 0 && q[0].due == cyc) begin
            m_rv   = 32'(1) << q[0].id;
            m_last = q[0].res;
            void'(q.pop_front());
         end
         chk("resp_valid", 32'(resp_valid), m_rv);
         chk("resp_data", resp_data, m_last);
         chk("busy", 32'(busy), 32'((q.size() > 0) || (m_rv != 0)));
         m_gnt = hold ? -1 : pick(req_valid, m_ptr);
         m_rdy = (m_gnt < 0) ? 32'h0 : (32'(1) << m_gnt);
         chk("req_ready", 32'(req_ready), m_rdy);
         if (m_gnt >= 0) begin
            m_mod = req_data[32*m_gnt +: 32];
            q.push_back('{due: cyc + LAT + 2, id: m_gnt, res: req_data[32*m_gnt +: 32] ^ 32'h1});
`ifndef AHFP_MOD_PI_ARB_FIXED_PRIO_EN
            m_ptr = (m_gnt + 1) % N;
`endif
         end else begin
            m_mod = '0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; hold = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // Single request from requester 0, response exactly LAT+1 edges after the handshake.
      req_valid = 4'b0001;
      req_data[31:0] = 32'h40A00000;
      #1 chk("single_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("single_mod_data", mod_data, 32'h40A00000);
      repeat (24) tick();
      #1 chk("single_resp_early", 32'(resp_valid), 32'h0);
      tick();
      #1 chk("single_resp_valid", 32'(resp_valid), 32'h1);
      chk("single_resp_data", resp_data, 32'h40A00001);
      tick();
      #1 chk("single_resp_once", 32'(resp_valid), 32'h0);

`ifndef AHFP_MOD_PI_ARB_FIXED_PRIO_EN
      // Everyone requesting: grants rotate 0,1,2,3,... and responses follow in that order.
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'h1000 + i;
      for (int k = 0; k < 8; k++) begin
         #1 chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
         tick();
      end
      req_valid = '0;
      repeat (18) tick();
      for (int k = 0; k < 4; k++) begin
         #1 chk("rr_resp", 32'(resp_valid), 32'(1) << k);
         tick();
      end

      // Pointer parked at 2 with requesters 1 and 3 pending: 3 first, then wrap to 1.
      do_reset();
      req_valid = 4'b0010;
      #1 chk("skip_setup", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b1010;
      #1 chk("skip_first", 32'(req_ready), 32'h8);
      tick();
      #1 chk("skip_second", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
`else
      // Fixed priority: requester 0 always beats requester 3.
      do_reset();
      req_valid = 4'b1001;
      for (int k = 0; k < 10; k++) begin
         #1 chk("fixed_grant", 32'(req_ready), 32'h1);
         tick();
      end
      req_valid = '0;
`endif

      // Hold blocks new grants while an earlier operand still drains.
      do_reset();
      req_valid = 4'b0001;
      req_data[31:0] = 32'h11110000;
      tick();
      req_valid = '0;
      repeat (20) tick();
      hold = 1'b1;
      req_valid = 4'b0100;
      req_data[95:64] = 32'h3F800000;
      for (int j = 0; j < 10; j++) begin
         #1 chk("hold_no_grant", 32'(req_ready), 32'h0);
         if (j == 5) chk("hold_drain_resp", 32'(resp_valid), 32'h1);
         tick();
      end
      hold = 1'b0;
      #1 chk("hold_release_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      repeat (24) tick();
      #1 chk("hold_resp_early", 32'(resp_valid), 32'h0);
      tick();
      #1 chk("hold_resp_valid", 32'(resp_valid), 32'h4);
      chk("hold_resp_data", resp_data, 32'h3F800001);

      // Reset with operands in flight: nothing may ever be strobed afterwards.
      do_reset();
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         req_data[31:0] = 32'hA0 + k;
         tick();
      end
      req_valid = '0;
      tick();
      rst = 1'b1;
      #1 chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         #1 chk("midrst_no_resp", 32'(resp_valid), 32'h0);
         tick();
      end

      // Random traffic: requesters keep data stable until granted; occasional hold and reset.
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && m_gnt == i) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_data[32*i +: 32] = $urandom;
            end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               req_data[32*i +: 32] = $urandom;
            end
         end
         hold = ($urandom_range(0, 9) == 0);
         tick();
      end
      req_valid = '0;
      hold = 1'b0;
      repeat (40) tick();
      #1 chk("drain_idle", 32'(busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ahfp_mod_pi_arb.md
# ahfp_mod_pi_arb

Round-robin arbiter that shares one `ahfp_mod_pi` pipeline between `N_REQ` requesters (e.g. the sine/cosine argument-reduction front ends). Grants one operand per cycle into the shared pipeline and tracks the owner of each in-flight operand with a tag shift register matched to the pipeline latency. Steers each result back to its owner as a one-cycle valid pulse. The pipeline has no stall, so responses cannot be back-pressured.

## Interface
- `N_REQ`, 4: number of requesters, from 2 to 8.
- `LATENCY`, 24: `ahfp_mod_pi` latency in clock edges from `data` to `result`. It must match the instantiated pipeline.
- `TAG_W`, 3: tag width. It must satisfy `TAG_W` ≥ clog2(`N_REQ`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_data`  in  32·N_REQ  per-requester operand. Requester i uses bits [32i+31:32i].
- `req_ready`  out  N_REQ  one-hot grant (or all zero).
- `hold`  in  1  when high, suppresses new grants. In-flight operands still drain.
- `mod_data`  out  32  operand to the `ahfp_mod_pi` `data` input.
- `mod_result`  in  32  `ahfp_mod_pi` `result` output.
- `resp_valid`  out  N_REQ  one-hot, one-cycle result strobe.
- `resp_data`  out  32  result, shared by all requesters.
- `busy`  out  1  high when any operand is in flight.

## Operation
- **Grant logic:** combinational from `req_valid`, `hold` and the priority pointer `ptr`.
  - Search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - The first index with `req_valid` high gets `req_ready`.
  - No grant while `hold`=1 or `rst`=1.
- **Handshake:** a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high at a rising edge.
  - The requester must hold `req_data` stable while valid and not granted.
  - `req_ready` never depends on the same requester's data.
- **On a transfer from i:**
  - `mod_data` ← `req_data[i]`.
  - Tag stage 0 ← {valid=1, id=i}.
  - `ptr` ← (i+1) mod N_REQ.
- **With no transfer:**
  - `mod_data` ← 32'h0.
  - Tag stage 0 ← invalid.
  - `ptr` unchanged.
- **Tag pipeline:** LATENCY stages of {valid, id}, shifted every cycle unconditionally.
- **Response:** when the last tag stage is valid with id k, register `resp_data` ← `mod_result` and `resp_valid` ← one-hot(k).
  - Otherwise `resp_valid` ← 0 and `resp_data` holds its previous value.
- **Ordering:** responses return in grant order. At most one response per cycle.
- **`busy`:** OR of all tag valid bits, OR `resp_valid` pending.
- **Reset:** asynchronous clear of all state.
  - `ptr`=0, `mod_data`=0, all tags invalid.
  - `resp_valid`=0, `resp_data`=0, `req_ready`=0, `busy`=0.
  - Reset mid-operation discards every in-flight operand. Pipeline garbage that emerges after reset is never strobed, because its tags are invalid.
- **Boundary cases:**
  - If N_REQ is not a power of two, `ptr` wraps from N_REQ-1 to 0.
  - Id values ≥ N_REQ are unreachable.
  - A single requester holding `req_valid` high with no competitors is granted every cycle, at full throughput.
  - `hold` rising in the same cycle as a pending request: no grant that cycle.

## Timing
- The handshake at edge E puts the operand on `mod_data` from E.
- `mod_result` for that operand is valid after edge E+LATENCY.
- `resp_valid`/`resp_data` are asserted after edge E+LATENCY+1, for exactly one cycle.
- Throughput is one operand per cycle, aggregate.
- Under continuous contention, each requester waits at most N_REQ-1 cycles between grants.
- `req_ready` is combinational. All other outputs are registered.

## Configuration
- `AHFP_MOD_PI_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority. The lowest valid index always wins, `ptr` is removed, and starvation is possible by design.
  - **Undefined (default):** round-robin as described above.

## Test plan
- **Reset and single request.**
  - Bench stubs `ahfp_mod_pi` with a LATENCY=24 delay line plus XOR 32'h1.
  - After reset, requester 0 sends 32'h40A00000 at edge 10.
  - Required: `resp_valid`=4'b0001 and `resp_data`=32'h40A00001 after edge 35 only, for one cycle.
- **Round-robin under contention.**
  - All 4 requesters valid continuously from edge 5.
  - Required: grant order 0,1,2,3,0,…
  - Required: responses return with ids in the same order, one per cycle, starting after edge 30.
- **Pointer skip.**
  - Requesters 1 and 3 valid, `ptr`=2.
  - Required: 3 is granted first, then 1.
  - Required: `ptr` is 0 after the grant to 3.
- **Hold.**
  - Requester 2 valid, with `hold`=1 for edges 10–19.
  - Required: no `req_ready` during hold. Grant at edge 20. Response after edge 45.
  - Required: in-flight responses already issued still appear during hold.
- **Mid-flight reset.**
  - Issue 5 operands, then pulse `rst` at edge 8.
  - Required: `resp_valid` stays 0 for the next 30 cycles.
  - Required: `busy`=0 immediately after reset.
- **Fixed-priority build** (with `AHFP_MOD_PI_ARB_FIXED_PRIO_EN`).
  - Requesters 0 and 3 both valid for 10 cycles.
  - Required: only requester 0 is granted.
